// File: rtl/cntry_vehicle_detector.sv
// Country-road loop conditioner: 2-flop sync, debounce, saturating vehicle queue, and the
// car-waiting request X with max-green cap and highway holdoff. Optional macro: SENSOR_FAULT_EN.
module cntry_vehicle_detector #(
  parameter int DEBOUNCE     = 4,
  parameter int PASS_CYCLES  = 3,
  parameter int MAX_GREEN    = 20,
  parameter int MIN_HWY      = 10,
  parameter int CW           = 4,
  parameter int STUCK_CYCLES = 200
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          sensor_raw,
  input  logic [2:0]    cntry,
  output logic          X,
  output logic [CW-1:0] car_count,
  output logic          sensor_db,
  output logic          overflow,
  output logic          sensor_fault,
  output logic [1:0]    o_dbg_state
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int PW = $clog2(PASS_CYCLES + 1);
  localparam int GW = $clog2(MAX_GREEN + 1);
  localparam int HW = $clog2(MIN_HWY + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVING = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  logic          r_sync1, r_sync2, r_db, r_db_prev;
  logic [DW-1:0] r_db_cnt;
  logic [PW-1:0] r_pass_tmr;
  logic [CW-1:0] r_count;
  logic          r_ovf, r_x;
  logic [GW-1:0] r_green_tmr, w_green_tmr_nxt, w_green_inc;
  logic [HW-1:0] r_hold_tmr, w_hold_tmr_nxt;
  state_t        r_state, w_state_nxt;
  logic          w_green, w_red, w_has_cars, w_arrival, w_depart, w_pass_run, w_fault;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_db      <= 1'b0;
      r_db_prev <= 1'b0;
      r_db_cnt  <= '0;
    end else begin
      r_sync1   <= sensor_raw;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      if (r_sync2 == r_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DW'(DEBOUNCE - 1)) begin
        r_db     <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_green    = (cntry == 3'b001);
  assign w_red      = (cntry == 3'b100);
  assign w_arrival  = r_db & ~r_db_prev & ~w_fault;
  assign w_pass_run = w_green && (r_count != '0);
  assign w_depart   = w_pass_run && (r_pass_tmr == PW'(PASS_CYCLES - 1));
  assign w_has_cars = (r_count != '0) || w_fault;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_pass_tmr <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (!w_pass_run || w_depart) r_pass_tmr <= '0;
      else                         r_pass_tmr <= r_pass_tmr + 1'b1;
      // A simultaneous arrival and departure cancel out.
      if (w_arrival && !w_depart) begin
        if (r_count == {CW{1'b1}}) r_ovf   <= 1'b1;
        else                       r_count <= r_count + 1'b1;
      end else if (w_depart && !w_arrival) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign w_green_inc = r_green_tmr + 1'b1;

  always_comb begin
    w_state_nxt     = r_state;
    w_green_tmr_nxt = r_green_tmr;
    w_hold_tmr_nxt  = r_hold_tmr;
    case (r_state)
      IDLE: begin
        if (w_has_cars) w_state_nxt = REQUEST;
      end
      REQUEST: begin
        if (w_green) begin
          w_state_nxt     = SERVING;
          w_green_tmr_nxt = '0;
        end
      end
      SERVING: begin
        // The green cycle seen in REQUEST counts toward the cap, so X is high for at most MAX_GREEN green cycles.
        if (!w_has_cars || !w_green || (w_green_inc == GW'(MAX_GREEN - 1))) begin
          w_state_nxt    = HOLDOFF;
          w_hold_tmr_nxt = '0;
        end else begin
          w_green_tmr_nxt = w_green_inc;
        end
      end
      HOLDOFF: begin
        if (w_red || (r_hold_tmr != '0)) begin
          if (r_hold_tmr == HW'(MIN_HWY - 1)) begin
            w_state_nxt    = IDLE;
            w_hold_tmr_nxt = '0;
          end else begin
            w_hold_tmr_nxt = r_hold_tmr + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state     <= IDLE;
      r_green_tmr <= '0;
      r_hold_tmr  <= '0;
      r_x         <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_green_tmr <= w_green_tmr_nxt;
      r_hold_tmr  <= w_hold_tmr_nxt;
      r_x         <= (w_state_nxt == REQUEST) || (w_state_nxt == SERVING);
    end
  end

`ifdef SENSOR_FAULT_EN
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  logic [SW-1:0] r_stuck_tmr;
  logic          r_fault;

  // Sticky until clear; a faulted sensor keeps the country road cycling.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_stuck_tmr <= '0;
      r_fault     <= 1'b0;
    end else if (!r_db) begin
      r_stuck_tmr <= '0;
    end else if (!r_fault) begin
      if (r_stuck_tmr == SW'(STUCK_CYCLES - 1)) r_fault <= 1'b1;
      r_stuck_tmr <= r_stuck_tmr + 1'b1;
    end
  end
  assign w_fault = r_fault;
`else
  assign w_fault = 1'b0;
`endif

  assign X            = r_x;
  assign car_count    = r_count;
  assign sensor_db    = r_db;
  assign overflow     = r_ovf;
  assign sensor_fault = w_fault;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_cntry_vehicle_detector.sv
// Bench for cntry_vehicle_detector: directed scenarios plus randomized traffic, all checked
// against a cycle-level behavioural model of the sensor, queue and request timing.
module tb_cntry_vehicle_detector;
  localparam int DEBOUNCE     = 4;
  localparam int PASS_CYCLES  = 3;
  localparam int MAX_GREEN    = 20;
  localparam int MIN_HWY      = 10;
  localparam int CW           = 4;
  localparam int STUCK_CYCLES = 200;
  localparam int CNT_MAX      = (1 << CW) - 1;
  localparam int M_WAIT = 0, M_ASK = 1, M_GREEN = 2, M_HWY = 3;

  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic          sensor_raw = 1'b0;
  logic [2:0]    cntry = 3'b100;
  logic          X;
  logic [CW-1:0] car_count;
  logic          sensor_db, overflow, sensor_fault;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit hist[$];
  int m_db, m_db_last, m_run, m_pass, m_count, m_ovf;
  int m_mode, m_gcnt, m_rcnt, m_stuck, m_fault;

  cntry_vehicle_detector #(
    .DEBOUNCE(DEBOUNCE), .PASS_CYCLES(PASS_CYCLES), .MAX_GREEN(MAX_GREEN),
    .MIN_HWY(MIN_HWY), .CW(CW), .STUCK_CYCLES(STUCK_CYCLES)
  ) dut (
    .clock(clock), .clear(clear), .sensor_raw(sensor_raw), .cntry(cntry),
    .X(X), .car_count(car_count), .sensor_db(sensor_db), .overflow(overflow),
    .sensor_fault(sensor_fault), .o_dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  function automatic void model_reset();
    hist.delete();
    m_db = 0; m_db_last = 0; m_run = 0; m_pass = 0; m_count = 0; m_ovf = 0;
    m_mode = M_WAIT; m_gcnt = 0; m_rcnt = 0; m_stuck = 0; m_fault = 0;
  endfunction

  // One rising edge of the reference model, using the inputs held before that edge.
  function automatic void model_edge(input bit raw, input logic [2:0] c);
    bit syn, arr, dep, green, red, has;
    syn = (hist.size() >= 2) ? hist[hist.size() - 2] : 1'b0;
    hist.push_back(raw);
    if (hist.size() > 4) void'(hist.pop_front());
    green = (c == 3'b001);
    red   = (c == 3'b100);
    arr   = (m_db == 1) && (m_db_last == 0) && (m_fault == 0);
    has   = (m_count > 0) || (m_fault == 1);
    dep   = 1'b0;
    if (green && m_count > 0) begin
      if (m_pass == PASS_CYCLES - 1) begin dep = 1'b1; m_pass = 0; end
      else m_pass++;
    end else m_pass = 0;
    case (m_mode)
      M_WAIT:  if (has) m_mode = M_ASK;
      M_ASK:   if (green) begin m_mode = M_GREEN; m_gcnt = 1; end
      M_GREEN: begin
        m_gcnt++;
        if (!has || !green || m_gcnt == MAX_GREEN) begin m_mode = M_HWY; m_rcnt = 0; end
      end
      default: begin
        if (red || m_rcnt > 0) begin
          m_rcnt++;
          if (m_rcnt == MIN_HWY) begin m_mode = M_WAIT; m_rcnt = 0; end
        end
      end
    endcase
    if (arr && !dep) begin
      if (m_count == CNT_MAX) m_ovf = 1;
      else m_count++;
    end else if (dep && !arr) m_count--;
`ifdef SENSOR_FAULT_EN
    if (m_db == 1) begin
      if (m_stuck < STUCK_CYCLES) m_stuck++;
      if (m_stuck == STUCK_CYCLES) m_fault = 1;
    end else m_stuck = 0;
`endif
    m_db_last = m_db;
    if (int'(syn) != m_db) begin
      m_run++;
      if (m_run == DEBOUNCE) begin m_db = 1 - m_db; m_run = 0; end
    end else m_run = 0;
  endfunction

  function automatic logic [CW+3:0] model_outs();
    logic mx;
    mx = (m_mode == M_ASK) || (m_mode == M_GREEN);
    return {mx, m_count[CW-1:0], m_db[0], m_ovf[0], m_fault[0]};
  endfunction

  task automatic step();
    @(posedge clock);
    model_edge(sensor_raw, cntry);
    @(negedge clock);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    clear = 1'b1; sensor_raw = 1'b0; cntry = 3'b100;
    @(negedge clock);
    clear = 1'b0;
    model_reset();
  endtask

  task automatic pulse(input int hi, input int lo);
    sensor_raw = 1'b1;
    repeat (hi) step();
    sensor_raw = 1'b0;
    repeat (lo) step();
  endtask

  task automatic test_reset();
    clear = 1'b1; sensor_raw = 1'b0; cntry = 3'b100;
    repeat (5) begin
      @(negedge clock);
      n_checks++;
      if ({X, car_count, sensor_db, overflow, sensor_fault} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs got=%b exp=0", {X, car_count, sensor_db, overflow, sensor_fault});
      end
    end
    clear = 1'b0;
    model_reset();
  endtask

  task automatic test_glitch();
    int rise_at;
    apply_reset();
    sensor_raw = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k == 3) sensor_raw = 1'b0;
      n_checks++;
      if (sensor_db !== 1'b0) begin n_fail++; $display("FAIL glitch_db step=%0d got=%b exp=0", k, sensor_db); end
    end
    n_checks++;
    if (car_count !== '0) begin n_fail++; $display("FAIL glitch_count got=%0d exp=0", car_count); end
    rise_at = 0;
    sensor_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 8) sensor_raw = 1'b0;
      if (sensor_db === 1'b1 && rise_at == 0) rise_at = k;
      n_checks++;
      if (sensor_db !== m_db[0]) begin n_fail++; $display("FAIL pulse_db step=%0d got=%b exp=%0d", k, sensor_db, m_db); end
      if (k == 7) begin
        n_checks++;
        if (car_count !== 4'd1 || X !== 1'b0) begin n_fail++; $display("FAIL pulse_count got=%0d/X=%b exp=1/X=0", car_count, X); end
      end
      if (k == 8) begin
        n_checks++;
        if (X !== 1'b1) begin n_fail++; $display("FAIL pulse_x got=%b exp=1", X); end
      end
    end
    n_checks++;
    if (rise_at != 2 + DEBOUNCE) begin n_fail++; $display("FAIL db_latency got=%0d exp=%0d", rise_at, 2 + DEBOUNCE); end
  endtask

  task automatic test_serve3();
    int zero_at, low_at;
    apply_reset();
    repeat (3) pulse(8, 10);
    n_checks++;
    if (car_count !== 4'd3 || X !== 1'b1) begin n_fail++; $display("FAIL serve3_queued got=%0d/X=%b exp=3/X=1", car_count, X); end
    cntry = 3'b001;
    zero_at = 0; low_at = 0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (car_count === '0 && zero_at == 0) zero_at = k;
      if (X === 1'b0 && low_at == 0) low_at = k;
      n_checks++;
      if ({X, car_count} !== {model_outs()[CW+3], m_count[CW-1:0]}) begin
        n_fail++; $display("FAIL serve3_step k=%0d got=%b/%0d exp=%b/%0d", k, X, car_count, model_outs()[CW+3], m_count);
      end
    end
    n_checks++;
    if (zero_at != 3 * PASS_CYCLES || low_at != zero_at + 1) begin
      n_fail++; $display("FAIL serve3_timing got=%0d/%0d exp=%0d/%0d", zero_at, low_at, 3 * PASS_CYCLES, 3 * PASS_CYCLES + 1);
    end
    cntry = 3'b100;
    for (int k = 1; k <= MIN_HWY + 2; k++) begin
      step();
      n_checks++;
      if (X !== 1'b0) begin n_fail++; $display("FAIL serve3_holdoff k=%0d got=%b exp=0", k, X); end
    end
  endtask

  task automatic test_max_green();
    int rise_at;
    apply_reset();
    repeat (15) pulse(8, 8);
    n_checks++;
    if (car_count !== 4'd15) begin n_fail++; $display("FAIL maxg_queued got=%0d exp=15", car_count); end
    cntry = 3'b001;
    for (int k = 1; k <= MAX_GREEN; k++) begin
      step();
      n_checks++;
      if (k < MAX_GREEN && X !== 1'b1) begin n_fail++; $display("FAIL maxg_high k=%0d got=%b exp=1", k, X); end
      if (k == MAX_GREEN && (X !== 1'b0 || car_count !== 4'd9)) begin
        n_fail++; $display("FAIL maxg_cap got=X%b/%0d exp=X0/9", X, car_count);
      end
    end
    cntry = 3'b100;
    rise_at = 0;
    for (int k = 1; k <= MIN_HWY + 4; k++) begin
      step();
      if (X === 1'b1 && rise_at == 0) rise_at = k;
      n_checks++;
      if (X !== model_outs()[CW+3]) begin n_fail++; $display("FAIL maxg_hold k=%0d got=%b exp=%b", k, X, model_outs()[CW+3]); end
    end
    n_checks++;
    if (rise_at != MIN_HWY + 1) begin n_fail++; $display("FAIL maxg_reassert got=%0d exp=%0d", rise_at, MIN_HWY + 1); end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      pulse(8, 8);
      if (i == 14) begin
        n_checks++;
        if (car_count !== 4'd15 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_full got=%0d/%b exp=15/0", car_count, overflow); end
      end
    end
    n_checks++;
    if (car_count !== 4'd15 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%0d/%b exp=15/1", car_count, overflow); end
    // Arrival timed to land on the third departure pulse.
    cntry = 3'b001;
    step(); step();
    sensor_raw = 1'b1;
    for (int k = 3; k <= 40; k++) begin
      step();
      if (k == 10) sensor_raw = 1'b0;
      if (k == 8 || k == 9) begin
        n_checks++;
        if (car_count !== 4'd13) begin n_fail++; $display("FAIL coincide k=%0d got=%0d exp=13", k, car_count); end
      end
      if (k == 12) begin
        n_checks++;
        if (car_count !== 4'd12) begin n_fail++; $display("FAIL after_coincide got=%0d exp=12", car_count); end
      end
    end
    n_checks++;
    if (overflow !== 1'b1 || {X, car_count} !== {model_outs()[CW+3], m_count[CW-1:0]}) begin
      n_fail++; $display("FAIL ovf_sticky got=%b/%b/%0d exp=1/%b/%0d", overflow, X, car_count, model_outs()[CW+3], m_count);
    end
  endtask

  task automatic test_clear_mid();
    logic [1:0] idle_code;
    apply_reset();
    idle_code = dbg_state;
    pulse(8, 4);
    cntry = 3'b001;
    step(); step();
    n_checks++;
    if (X !== 1'b1 || dbg_state === idle_code) begin n_fail++; $display("FAIL mid_serving got=X%b st=%0d", X, dbg_state); end
    clear = 1'b1;
    #1;
    n_checks++;
    if ({X, car_count, sensor_db, overflow, sensor_fault} !== '0 || dbg_state !== idle_code) begin
      n_fail++; $display("FAIL clear_mid got=%b st=%0d exp=0", {X, car_count, sensor_db, overflow, sensor_fault}, dbg_state);
    end
    @(negedge clock);
    clear = 1'b0; sensor_raw = 1'b0; cntry = 3'b100;
    model_reset();
  endtask

  task automatic test_fault();
    int rise_at;
    logic [CW+3:0] exp;
    apply_reset();
    sensor_raw = 1'b1;
    rise_at = 0;
    for (int k = 1; k <= 250; k++) begin
      step();
      if (sensor_fault === 1'b1 && rise_at == 0) rise_at = k;
    end
    n_checks++;
`ifdef SENSOR_FAULT_EN
    if (rise_at != 2 + DEBOUNCE + STUCK_CYCLES) begin
      n_fail++; $display("FAIL fault_time got=%0d exp=%0d", rise_at, 2 + DEBOUNCE + STUCK_CYCLES);
    end
`else
    if (rise_at != 0) begin n_fail++; $display("FAIL fault_tied got=%0d exp=0", rise_at); end
`endif
    // Controller stand-in: give green whenever the request is up.
    for (int k = 1; k <= 150; k++) begin
      cntry = X ? 3'b001 : 3'b100;
      step();
      exp = model_outs();
      n_checks++;
      if ({X, car_count, sensor_db, overflow, sensor_fault} !== exp) begin
        n_fail++; $display("FAIL fault_cycle k=%0d got=%b exp=%b", k, {X, car_count, sensor_db, overflow, sensor_fault}, exp);
      end
    end
  endtask

  task automatic test_random();
    int raw_left, c_left, sel;
    logic [CW+3:0] exp;
    apply_reset();
    raw_left = 0; c_left = 0;
    for (int k = 0; k < 1500; k++) begin
      if (raw_left == 0) begin
        sensor_raw = ~sensor_raw;
        raw_left = sensor_raw ? $urandom_range(1, 12) : $urandom_range(1, 14);
      end
      if (c_left == 0) begin
        sel = $urandom_range(0, 5);
        case (sel)
          0, 1:    cntry = 3'b001;
          2:       cntry = 3'b100;
          3:       cntry = 3'b010;
          4:       cntry = 3'b000;
          default: cntry = 3'b011;
        endcase
        c_left = $urandom_range(1, 40);
      end
      raw_left--; c_left--;
      step();
      exp = model_outs();
      n_checks++;
      if ({X, car_count, sensor_db, overflow, sensor_fault} !== exp) begin
        n_fail++; $display("FAIL random k=%0d got=%b exp=%b", k, {X, car_count, sensor_db, overflow, sensor_fault}, exp);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_glitch();
    test_serve3();
    test_max_green();
    test_overflow();
    test_clear_mid();
    test_fault();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
